// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data-memory access controller.
package mem_access_ctrl_pkg;

    localparam int unsigned DATA_WIDTH          = 32;
    localparam int unsigned MAC_TIMEOUT_DEFAULT = 255;

    typedef enum logic [1:0] {
        MAC_ST_IDLE        = 2'd0,
        MAC_ST_WAIT_GNT    = 2'd1,
        MAC_ST_WAIT_RVALID = 2'd2,
        MAC_ST_ERROR       = 2'd3
    } mac_state_e;

endpackage

// File: rtl/mem_access_ctrl_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones once reached.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Count enabled cycles, sticking at the maximum value.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: drives EX/MEM loads/stores onto a handshaked,
// variable-latency data-memory port, stalls the upstream pipeline while an
// access is outstanding, and flags a sticky timeout error.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = MAC_TIMEOUT_DEFAULT,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = DATA_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    output logic              stall_o,
    output logic              wb_bubble_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o,
    output logic [31:0]       stall_cnt_o
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    mac_state_e         state, state_next;
    logic [TIMER_W-1:0] timer;
    logic               op;
    logic               complete;
    logic               req_raw;
    logic               stall_raw;

    assign op = mem_read_i | mem_write_i;

    // Request fields come straight from EX/MEM, which is frozen while stalled.
    assign dmem_we_o    = mem_write_i;
    assign dmem_addr_o  = addr_i;
    assign dmem_wdata_o = wdata_i;
    assign rdata_o      = dmem_rdata_i;
    assign err_o        = (state == MAC_ST_ERROR);

    // Handshake sequencing; timeout overrides any other transition.
    always_comb begin
        state_next = state;
        req_raw    = 1'b0;
        complete   = 1'b0;
        unique case (state)
            MAC_ST_IDLE: begin
                req_raw = op;
                if (op) begin
                    if (dmem_gnt_i) begin
                        if (mem_write_i) complete   = 1'b1;
                        else             state_next = MAC_ST_WAIT_RVALID;
                    end else begin
                        state_next = MAC_ST_WAIT_GNT;
                    end
                end
            end
            MAC_ST_WAIT_GNT: begin
                req_raw = 1'b1;
                if (dmem_gnt_i) begin
                    if (mem_write_i) begin
                        complete   = 1'b1;
                        state_next = MAC_ST_IDLE;
                    end else begin
                        state_next = MAC_ST_WAIT_RVALID;
                    end
                end
            end
            MAC_ST_WAIT_RVALID: begin
                if (dmem_rvalid_i) begin
                    complete   = 1'b1;
                    state_next = MAC_ST_IDLE;
                end
            end
            MAC_ST_ERROR: begin
                state_next = MAC_ST_ERROR;
            end
            default: state_next = MAC_ST_IDLE;
        endcase

        stall_raw = op && !complete && (state != MAC_ST_ERROR);
        if (stall_raw && (timer == TIMER_LAST)) begin
            state_next = MAC_ST_ERROR;
        end
    end

    // Pipeline-facing outputs are held inactive while in reset.
    always_comb begin
        dmem_req_o  = 1'b0;
        stall_o     = 1'b0;
        wb_bubble_o = 1'b0;
        if (!reset) begin
            dmem_req_o  = req_raw;
            stall_o     = stall_raw;
            wb_bubble_o = stall_raw || ((state == MAC_ST_ERROR) && op);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= MAC_ST_IDLE;
        else       state <= state_next;
    end

    // Outstanding-access timer: counts stalled cycles, cleared on completion.
    always_ff @(posedge clk) begin
        if (reset || complete) begin
            timer <= '0;
        end else if (stall_raw) begin
            timer <= timer + 1'b1;
        end
    end

    sat_counter #(
        .WIDTH(32)
    ) u_stall_cnt (
        .clk  (clk),
        .reset(reset),
        .en   (stall_o),
        .count(stall_cnt_o)
    );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: one default-timeout instance and one
// with a short timeout sharing the same stimulus.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write;
    logic [31:0] addr, wdata;
    logic        gnt, rvalid;
    logic [31:0] rdata_in;

    logic        req, we, stall, bubble, err;
    logic [31:0] maddr, mwdata, rdata, scnt;

    logic        to_req, to_we, to_stall, to_bubble, to_err;
    logic [31:0] to_maddr, to_mwdata, to_rdata, to_scnt;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned hi_cnt, bub_cnt;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk(clk), .reset(reset),
        .mem_read_i(mem_read), .mem_write_i(mem_write),
        .addr_i(addr), .wdata_i(wdata),
        .dmem_req_o(req), .dmem_we_o(we),
        .dmem_addr_o(maddr), .dmem_wdata_o(mwdata),
        .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata_in),
        .stall_o(stall), .wb_bubble_o(bubble), .rdata_o(rdata),
        .err_o(err), .stall_cnt_o(scnt)
    );

    mem_access_ctrl #(
        .TIMEOUT_CYCLES(4)
    ) dut_to (
        .clk(clk), .reset(reset),
        .mem_read_i(mem_read), .mem_write_i(mem_write),
        .addr_i(addr), .wdata_i(wdata),
        .dmem_req_o(to_req), .dmem_we_o(to_we),
        .dmem_addr_o(to_maddr), .dmem_wdata_o(to_mwdata),
        .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata_in),
        .stall_o(to_stall), .wb_bubble_o(to_bubble), .rdata_o(to_rdata),
        .err_o(to_err), .stall_cnt_o(to_scnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Inputs change 1 time unit after the rising edge; checks run at the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_read = 0; mem_write = 0; gnt = 0; rvalid = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        idle_inputs();
        step();
        reset = 0;
    endtask

    initial begin
        reset = 1; addr = '0; wdata = '0; rdata_in = '0;
        idle_inputs();
        step();

        // Outputs forced low during reset even with a load presented.
        mem_read = 1; gnt = 0;
        @(negedge clk);
        check("rst_req", {31'b0, req}, 0);
        check("rst_stall", {31'b0, stall}, 0);
        check("rst_bubble", {31'b0, bubble}, 0);
        check("rst_err", {31'b0, err}, 0);
        check("rst_cnt", scnt, 0);
        step();
        reset = 0;
        idle_inputs();

        // Store granted in its first cycle: no stall.
        mem_write = 1; addr = 32'h100; wdata = 32'h1234_5678; gnt = 1;
        @(negedge clk);
        check("st_req", {31'b0, req}, 1);
        check("st_we", {31'b0, we}, 1);
        check("st_addr", maddr, 32'h100);
        check("st_wdata", mwdata, 32'h1234_5678);
        check("st_stall", {31'b0, stall}, 0);
        check("st_bubble", {31'b0, bubble}, 0);
        step();
        idle_inputs();
        @(negedge clk);
        check("st_req_after", {31'b0, req}, 0);
        check("st_cnt", scnt, 0);
        step();

        // Load: gnt after 2 refusals, rvalid 3 cycles after gnt.
        hi_cnt = 0; bub_cnt = 0;
        mem_read = 1; addr = 32'h40;
        for (int c = 0; c < 6; c++) begin
            gnt      = (c == 2);
            rvalid   = (c == 5);
            rdata_in = (c == 5) ? 32'hDEAD_BEEF : 32'h0;
            @(negedge clk);
            if (stall)  hi_cnt++;
            if (bubble) bub_cnt++;
            if (c == 0) check("ld_req_c0", {31'b0, req}, 1);
            if (c == 2) check("ld_we_c2", {31'b0, we}, 0);
            if (c == 3) check("ld_req_c3", {31'b0, req}, 0);
            if (c == 5) begin
                check("ld_stall_done", {31'b0, stall}, 0);
                check("ld_rdata", rdata, 32'hDEAD_BEEF);
            end
            step();
        end
        idle_inputs();
        @(negedge clk);
        check("ld_stall_cycles", hi_cnt, 5);
        check("ld_bubble_cycles", bub_cnt, 5);
        check("ld_cnt", scnt, 5);

        // Spurious rvalid with nothing outstanding.
        rvalid = 1;
        @(negedge clk);
        check("sp_req", {31'b0, req}, 0);
        check("sp_stall", {31'b0, stall}, 0);
        check("sp_bubble", {31'b0, bubble}, 0);
        step();
        rvalid = 0;
        @(negedge clk);
        check("sp_state", {30'b0, dut.state}, 0);
        check("sp_cnt", scnt, 5);
        step();

        // Timeout on the short-timeout instance: store never granted.
        do_reset();
        hi_cnt = 0;
        mem_write = 1; addr = 32'h200;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (to_stall) hi_cnt++;
            if (c >= 4) begin
                check("to_req_err", {31'b0, to_req}, 0);
                check("to_stall_err", {31'b0, to_stall}, 0);
                check("to_bubble_err", {31'b0, to_bubble}, 1);
                check("to_err_flag", {31'b0, to_err}, 1);
            end else begin
                check("to_err_early", {31'b0, to_err}, 0);
            end
            step();
        end
        check("to_stall_cycles", hi_cnt, 4);
        check("to_cnt", to_scnt, 4);
        mem_write = 0; mem_read = 1; addr = 32'h300; gnt = 1;
        @(negedge clk);
        check("to_ld_req", {31'b0, to_req}, 0);
        check("to_ld_bubble", {31'b0, to_bubble}, 1);
        check("to_ld_stall", {31'b0, to_stall}, 0);
        step();
        idle_inputs();
        @(negedge clk);
        check("to_idle_bubble", {31'b0, to_bubble}, 0);
        check("to_sticky", {31'b0, to_err}, 1);
        step();

        // Reset while waiting for rvalid; the late rvalid is ignored.
        do_reset();
        mem_read = 1; addr = 32'h44; gnt = 1;
        step();
        gnt = 0;
        @(negedge clk);
        check("rr_wait_state", {30'b0, dut.state}, 2);
        check("rr_wait_stall", {31'b0, stall}, 1);
        reset = 1;
        @(negedge clk);
        check("rr_in_reset_stall", {31'b0, stall}, 0);
        check("rr_in_reset_req", {31'b0, req}, 0);
        step();
        reset = 0; mem_read = 0; rvalid = 1; rdata_in = 32'hCAFE_F00D;
        @(negedge clk);
        check("rr_state", {30'b0, dut.state}, 0);
        check("rr_timer", {24'b0, dut.timer}, 0);
        check("rr_cnt", scnt, 0);
        check("rr_req", {31'b0, req}, 0);
        step();
        rvalid = 0;
        @(negedge clk);
        check("rr_state_after", {30'b0, dut.state}, 0);
        check("rr_stall_after", {31'b0, stall}, 0);
        step();

        // Saturation of the stall-cycle counter.
        @(negedge clk);
        force dut.u_stall_cnt.count = 32'hFFFF_FFFE;
        #1;
        release dut.u_stall_cnt.count;
        step();
        mem_read = 1; gnt = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            @(negedge clk);
            check("sat_cnt", scnt, 32'hFFFF_FFFF);
        end
        do_reset();
        @(negedge clk);
        check("sat_reset_cnt", scnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencing controller for the MEM stage: takes the load/store presented by the EX/MEM latch outputs and drives it onto a handshaked, variable-latency data-memory port. While an access is outstanding it freezes the upstream pipeline (PC, IF/ID, ID/EX, EX/MEM) and injects bubbles into MEM/WB. It also provides a sticky timeout error and a saturating stall-cycle performance counter.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles an access may stay outstanding, counted from first request cycle (≥2)
- ADDR_W, 32: data-memory address width
- DATA_W, 32: data width (equals `DATA_WIDTH`)

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- mem_read_i  in  1  load in MEM (EX/MEM mem_read output)
- mem_write_i  in  1  store in MEM (EX/MEM mem_write output)
- addr_i  in  ADDR_W  access address (EX/MEM ALU result)
- wdata_i  in  DATA_W  store data (EX/MEM rt value)
- dmem_req_o  out  1  request valid
- dmem_we_o  out  1  1=write, 0=read
- dmem_addr_o  out  ADDR_W  request address
- dmem_wdata_o  out  DATA_W  write data
- dmem_gnt_i  in  1  request accepted this cycle
- dmem_rvalid_i  in  1  read data valid
- dmem_rdata_i  in  DATA_W  read data
- stall_o  out  1  hold PC and IF/ID, ID/EX, EX/MEM
- wb_bubble_o  out  1  MEM/WB loads a bubble (reg_write=0) this edge
- rdata_o  out  DATA_W  load data to MEM/WB
- err_o  out  1  sticky timeout error
- stall_cnt_o  out  32  stall cycles since reset, saturating

## Operation
- op = mem_read_i | mem_write_i; mem_read_i & mem_write_i never both 1.
- States: IDLE, WAIT_GNT, WAIT_RVALID, ERROR.
- IDLE: dmem_req_o = op. Write+gnt → complete, stay IDLE. Read+gnt → WAIT_RVALID. op & !gnt → WAIT_GNT. No op → IDLE.
- WAIT_GNT: req=1; on gnt: write → complete, IDLE; read → WAIT_RVALID.
- WAIT_RVALID: req=0; on rvalid → complete, IDLE.
- dmem_we_o = mem_write_i, dmem_addr_o = addr_i, dmem_wdata_o = wdata_i (stable, because EX/MEM is held while stall_o=1).
- complete = (write & gnt in IDLE/WAIT_GNT) | (rvalid in WAIT_RVALID). rvalid in any other state is ignored.
- stall_o = op & !complete & state≠ERROR.
- wb_bubble_o = stall_o | (state==ERROR & op).
- rdata_o = dmem_rdata_i (combinational; meaningful only on read completion).
- Timer, width $clog2(TIMEOUT_CYCLES+1):
  - increments each cycle stall_o=1; clears on complete.
  - If timer == TIMEOUT_CYCLES-1 & stall_o → ERROR next cycle, err_o=1.
- ERROR: req=0, stall_o=0. Every op, including the timed-out one still held in EX/MEM, is dropped as a bubble. Exit only by reset.
- stall_cnt_o increments when stall_o=1 and saturates at 0xFFFFFFFF.
- Stall has priority: the hazard unit must not flush EX/MEM while stall_o=1. This block has no flush input.

## Timing
- Reset values: state IDLE, timer 0, err_o 0, stall_cnt_o 0.
- While reset=1: dmem_req_o, stall_o and wb_bubble_o are forced to 0.
- Reset during an outstanding access abandons it; the memory must tolerate a dropped req and a late rvalid, which is ignored in IDLE.
- Store granted in its first cycle: 0 stall cycles.
- Store granted after k refused cycles: k stall cycles.
- Load granted at cycle g, rvalid at cycle g+n (n≥1, rvalid never in the gnt cycle): stall_o high cycles 0..g+n-1, low on the rvalid cycle.
- MEM/WB captures rdata_o at the end of the load's completion cycle.
- Next instruction enters MEM the cycle after completion.
- No-op cycles: zero latency, all outputs pass-through.

## Structure
- Add to mips_pkg.vh:
  - state encodings `MAC_ST_IDLE/WAIT_GNT/WAIT_RVALID/ERROR` (2-bit)
  - `MAC_TIMEOUT_DEFAULT`
  - reuse `DATA_WIDTH`
- One natural sub-module: sat_counter (parameterised width, enable, saturating) for stall_cnt_o.

## Test plan
- Store at 0x100, gnt same cycle → stall_o never 1, one req cycle with we=1, stall_cnt_o=0.
- Load at 0x40, gnt after 2 refused cycles, rvalid 3 cycles after gnt with 0xDEADBEEF → stall_o high 5 cycles; MEM/WB gets 0xDEADBEEF; stall_cnt_o=5; 5 wb_bubble_o cycles.
- TIMEOUT_CYCLES=4, gnt never → 4 stall cycles, then ERROR, err_o=1; following load/store produce no req, wb_bubble_o=1, stall_o=0.
- Spurious rvalid in IDLE with no op → no effect on state or outputs.
- Reset asserted in WAIT_RVALID, then rvalid arrives → req 0, stall 0, state IDLE, counters 0, rvalid ignored.
- Force stall_cnt_o to 0xFFFFFFFE, then stall 3 cycles → stall_cnt_o holds 0xFFFFFFFF.
